// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

   typedef enum logic [2:0] {
      ARB  = 3'b001,
      HDR  = 3'b010,
      DATA = 3'b100
   } arb_state_e;

   localparam logic [7:0] HDR_SYNC = 8'hA0;

   // Header byte: sync pattern in the upper nibble, owner index in the lower.
   function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
      return HDR_SYNC | {4'h0, idx};
   endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side and transmitter-side beat handshakes of the UART arbiter.
interface uart_tx_arb_if #(
   parameter int NREQ = 4,
   parameter int DLEN = 8
);
   logic [NREQ-1:0]      i_req_valid;
   logic [NREQ-1:0]      o_req_ready;
   logic [NREQ*DLEN-1:0] i_req_data;
   logic [NREQ-1:0]      i_req_last;
   logic                 o_wvalid;
   logic                 i_wready;
   logic [DLEN-1:0]      o_wdata;

   modport master (
      output i_req_valid, i_req_data, i_req_last, i_wready,
      input  o_req_ready, o_wvalid, o_wdata
   );

   modport slave (
      input  i_req_valid, i_req_data, i_req_last, i_wready,
      output o_req_ready, o_wvalid, o_wdata
   );
endinterface

// File: rtl/uart_rr_pick.sv
// Round-robin pick: first set request scanning upward from last_i+1, wrapping.
module uart_rr_pick #(
   parameter int NREQ = 4,
   localparam int GW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [GW-1:0]   last_i,
   output logic            found_o,
   output logic [GW-1:0]   idx_o
);

   always_comb begin
      int c;
      c       = 0;
      found_o = 1'b0;
      idx_o   = '0;
      // Offset NREQ lands back on last_i, so the previous owner is checked last.
      for (int i = 1; i <= NREQ; i++) begin
         c = (int'(last_i) + i) % NREQ;
         if (!found_o && req_i[c]) begin
            found_o = 1'b1;
            idx_o   = c[GW-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb_core.sv
// Packet arbiter FSM: grants one requester, optionally sends a header, then forwards its beats.
//
//   state | meaning
//   ARB   | idle, picking the next owner round-robin (one cycle)
//   HDR   | offering the header byte for the granted requester
//   DATA  | forwarding the owner's beats until last or MAXLEN beats
module uart_tx_arb_core
   import uart_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int DLEN   = 8,
   parameter int HDR_EN = 1,
   parameter int MAXLEN = 64,
   localparam int GW    = $clog2(NREQ),
   localparam int CW    = $clog2(MAXLEN + 1)
) (
   input  logic          clk,
   input  logic          rstn,
   uart_tx_arb_if.slave  bus,
   output logic [GW-1:0] o_grant,
   output logic          o_busy,
   output logic          o_trunc
);

   arb_state_e      state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   last_q, last_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            trunc_q, trunc_d;

   logic            pick_found;
   logic [GW-1:0]   pick_idx;
   logic            wvalid;
   logic [DLEN-1:0] wdata;
   logic [NREQ-1:0] ready;

   uart_rr_pick #(.NREQ(NREQ)) u_pick (
      .req_i   (bus.i_req_valid),
      .last_i  (last_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ARB;
         grant_q <= '0;
         last_q  <= GW'(NREQ - 1);
         cnt_q   <= '0;
         trunc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         trunc_q <= trunc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      trunc_d = 1'b0;
      wvalid  = 1'b0;
      wdata   = '0;
      ready   = '0;
      case (state_q)
         ARB: begin
            if (pick_found) begin
               grant_d = pick_idx;
               state_d = (HDR_EN != 0) ? HDR : DATA;
            end
         end
         HDR: begin
            wvalid = 1'b1;
            wdata  = DLEN'(hdr_byte(4'(grant_q)));
            if (bus.i_wready) state_d = DATA;
         end
         DATA: begin
            wvalid         = bus.i_req_valid[grant_q];
            wdata          = bus.i_req_data[int'(grant_q)*DLEN +: DLEN];
            ready[grant_q] = bus.i_wready;
            if (wvalid && bus.i_wready) begin
               if (bus.i_req_last[grant_q]) begin
                  last_d  = grant_q;
                  cnt_d   = '0;
                  state_d = ARB;
               end else if (cnt_q == CW'(MAXLEN - 1)) begin
                  // Packet ran to MAXLEN beats without last: force it closed.
                  trunc_d = 1'b1;
                  last_d  = grant_q;
                  cnt_d   = '0;
                  state_d = ARB;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ARB;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.o_wvalid    = wvalid;
   assign bus.o_wdata     = wdata;
   assign bus.o_req_ready = ready;
   assign o_grant         = grant_q;
   assign o_busy          = (state_q == HDR) || (state_q == DATA);
   assign o_trunc         = trunc_q;

endmodule

// File: rtl/uart_tx_arb.sv
// UART transmit arbiter top: multiplexes NREQ packet sources onto one transmitter.
module uart_tx_arb #(
   parameter int NREQ   = 4,
   parameter int DLEN   = 8,
   parameter int HDR_EN = 1,
   parameter int MAXLEN = 64
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [NREQ-1:0]          i_req_valid,
   output logic [NREQ-1:0]          o_req_ready,
   input  logic [NREQ*DLEN-1:0]     i_req_data,
   input  logic [NREQ-1:0]          i_req_last,
   output logic                     o_wvalid,
   input  logic                     i_wready,
   output logic [DLEN-1:0]          o_wdata,
   output logic [$clog2(NREQ)-1:0]  o_grant,
   output logic                     o_busy,
   output logic                     o_trunc
);

   uart_tx_arb_if #(.NREQ(NREQ), .DLEN(DLEN)) bus ();

   assign bus.i_req_valid = i_req_valid;
   assign bus.i_req_data  = i_req_data;
   assign bus.i_req_last  = i_req_last;
   assign bus.i_wready    = i_wready;
   assign o_req_ready     = bus.o_req_ready;
   assign o_wvalid        = bus.o_wvalid;
   assign o_wdata         = bus.o_wdata;

   uart_tx_arb_core #(
      .NREQ   (NREQ),
      .DLEN   (DLEN),
      .HDR_EN (HDR_EN),
      .MAXLEN (MAXLEN)
   ) u_core (
      .clk     (clk),
      .rstn    (rstn),
      .bus     (bus),
      .o_grant (o_grant),
      .o_busy  (o_busy),
      .o_trunc (o_trunc)
   );

endmodule
